// File: rtl/ise_issue.sv
// rtl/ise_issue.sv - single-outstanding issue/response sequencer for the bit-manipulation ALU
//
// Purpose: accepts one ISE operation at a time from the core, presents it to
// the ALU from holding registers, waits up to TIMEOUT cycles for a result,
// and returns a tagged response with error flag plus delivery counters.
//
// Ports:
//   ise_clk, ise_rst                 clock, asynchronous active-high reset
//   req_valid/req_ready              request handshake from the core
//   req_fn, req_rs1, req_rs2, req_rd function code, operands, destination tag
//   ise_fn, ise_in1, ise_in2, ise_val  operation presented to the ALU
//   ise_oval, ise_out                ALU result valid / result
//   rsp_valid/rsp_ready              response handshake to the core
//   rsp_data, rsp_rd, rsp_err        response payload
//   done_cnt, err_cnt                good / errored responses delivered
module ise_issue #(
    parameter int TIMEOUT = 15
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_fn,
    input  logic [63:0] req_rs1,
    input  logic [63:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic [5:0]  ise_fn,
    output logic [63:0] ise_in1,
    output logic [63:0] ise_in2,
    output logic        ise_val,
    input  logic        ise_oval,
    input  logic [63:0] ise_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic [31:0] done_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    // Counter value seen in the last permitted BUSY cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [5:0]  fn_q, fn_d;
    logic [63:0] in1_q, in1_d;
    logic [63:0] in2_q, in2_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [63:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] done_q, done_d;
    logic [15:0] errc_q, errc_d;
    logic        ready_q, ready_d;
    logic        val_q, val_d;
    logic        rvalid_q, rvalid_d;
    logic        fn_legal;

    assign fn_legal = (req_fn >= 6'd32) && (req_fn <= 6'd43);

    always_comb begin
        state_d  = state_q;
        fn_d     = fn_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        rd_d     = rd_q;
        tmo_d    = tmo_q;
        data_d   = data_q;
        err_d    = err_q;
        done_d   = done_q;
        errc_d   = errc_q;
        ready_d  = ready_q;
        val_d    = val_q;
        rvalid_d = rvalid_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rd_d    = req_rd;
                    ready_d = 1'b0;
                    if (fn_legal) begin
                        fn_d    = req_fn;
                        in1_d   = req_rs1;
                        in2_d   = req_rs2;
                        tmo_d   = 8'd0;
                        val_d   = 1'b1;
                        state_d = S_BUSY;
                    end else begin
                        // Illegal function never reaches the ALU.
                        data_d   = 64'd0;
                        err_d    = 1'b1;
                        rvalid_d = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_BUSY: begin
                // A result arriving on the last timeout cycle still wins.
                if (ise_oval) begin
                    data_d   = ise_out;
                    err_d    = 1'b0;
                    val_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    data_d   = 64'd0;
                    err_d    = 1'b1;
                    val_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                    if (err_q) begin
                        if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
                    end else begin
                        done_d = done_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                val_d    = 1'b0;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            state_q  <= S_IDLE;
            fn_q     <= 6'd0;
            in1_q    <= 64'd0;
            in2_q    <= 64'd0;
            rd_q     <= 5'd0;
            tmo_q    <= 8'd0;
            data_q   <= 64'd0;
            err_q    <= 1'b0;
            done_q   <= 32'd0;
            errc_q   <= 16'd0;
            ready_q  <= 1'b1;
            val_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            rd_q     <= rd_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            err_q    <= err_d;
            done_q   <= done_d;
            errc_q   <= errc_d;
            ready_q  <= ready_d;
            val_q    <= val_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign req_ready = ready_q;
    assign ise_fn    = fn_q;
    assign ise_in1   = in1_q;
    assign ise_in2   = in2_q;
    assign ise_val   = val_q;
    assign rsp_valid = rvalid_q;
    assign rsp_data  = data_q;
    assign rsp_rd    = rd_q;
    assign rsp_err   = err_q;
    assign done_cnt  = done_q;
    assign err_cnt   = errc_q;

endmodule

// File: tb/tb_ise_issue.sv
// tb/tb_ise_issue.sv - scoreboard bench for ise_issue
module tb_ise_issue;

    logic        ise_clk = 1'b0;
    logic        ise_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_fn = 6'd0;
    logic [63:0] req_rs1 = 64'd0;
    logic [63:0] req_rs2 = 64'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [5:0]  ise_fn;
    logic [63:0] ise_in1;
    logic [63:0] ise_in2;
    logic        ise_val;
    logic        ise_oval;
    logic [63:0] ise_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic [31:0] done_cnt;
    logic [15:0] err_cnt;

    ise_issue #(.TIMEOUT(15)) dut (
        .ise_clk(ise_clk), .ise_rst(ise_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .ise_fn(ise_fn), .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_val(ise_val),
        .ise_oval(ise_oval), .ise_out(ise_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err), .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    always #5 ise_clk = ~ise_clk;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          exp_done = 0;
    int          exp_err = 0;
    int          val_cycles = 0;
    int          busy_cnt = 0;
    int          oval_at = 255;
    logic [63:0] alu_out = 64'd0;
    logic [5:0]  exp_fn = 6'd0;
    logic [63:0] exp_in1 = 64'd0;
    logic [63:0] exp_in2 = 64'd0;

    // ALU model: result becomes valid on BUSY cycle number oval_at (0-based).
    always @(posedge ise_clk) busy_cnt <= ise_val ? busy_cnt + 1 : 0;
    assign ise_oval = ise_val && (busy_cnt == oval_at);
    assign ise_out  = alu_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: checks ALU-side operands while busy and pops the scoreboard on each handshake.
    always @(negedge ise_clk) begin
        if (!ise_rst) begin
            if (ise_val) begin
                val_cycles++;
                chk("ise_fn_hold", ise_fn, exp_fn);
                chk("ise_in1_hold", ise_in1, exp_in1);
                chk("ise_in2_hold", ise_in2, exp_in2);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    rsp_t e;
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_rd", rsp_rd, e.rd);
                    chk("rsp_err", rsp_err, e.err);
                    if (e.err) exp_err++;
                    else exp_done++;
                end
            end
        end
    end

    task automatic drive_req(input logic [5:0] fn, input logic [63:0] a, input logic [63:0] b,
                             input logic [4:0] rd);
        req_valid = 1'b1;
        req_fn    = fn;
        req_rs1   = a;
        req_rs2   = b;
        req_rd    = rd;
    endtask

    // ecyc: expected BUSY cycles, which is also the edges from accept to rsp_valid.
    task automatic run_op(input logic [5:0] fn, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int oat, input logic [63:0] out,
                          input logic [63:0] edata, input logic eerr, input int ecyc);
        rsp_t e;
        int   lat;
        oval_at = oat;
        alu_out = out;
        exp_fn = fn;
        exp_in1 = a;
        exp_in2 = b;
        val_cycles = 0;
        e.data = edata;
        e.rd = rd;
        e.err = eerr;
        sb.push_back(e);
        chk("req_ready_idle", req_ready, 1'b1);
        drive_req(fn, a, b, rd);
        @(posedge ise_clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge ise_clk); #1;
            lat++;
        end
        chk("rsp_latency", lat, ecyc);
        @(posedge ise_clk); #1;
        chk("back_to_idle_ready", req_ready, 1'b1);
        chk("back_to_idle_rvalid", rsp_valid, 1'b0);
        chk("ise_val_cycles", val_cycles, ecyc);
        chk("done_cnt", done_cnt, exp_done);
        chk("err_cnt", err_cnt, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge ise_clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_ise_val", ise_val, 1'b0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        ise_rst = 1'b0;

        // Directed vectors: fn, rs1, rs2, rd, oval cycle, alu out, exp data, exp err, busy cycles
        run_op(6'd35, 64'hFF00, 64'h0F00, 5'd7, 0, 64'hF000, 64'hF000, 1'b0, 1);
        run_op(6'd12, 64'h1, 64'h2, 5'd3, 0, 64'h9999, 64'h0, 1'b1, 0);
        run_op(6'd31, 64'h5, 64'h6, 5'd1, 0, 64'h9999, 64'h0, 1'b1, 0);
        run_op(6'd32, 64'hA5A5, 64'h5A5A, 5'd2, 3, 64'h1234, 64'h1234, 1'b0, 4);
        run_op(6'd43, 64'hDEAD_BEEF_0000_0001, 64'h3, 5'd4, 0, 64'hCAFE, 64'hCAFE, 1'b0, 1);
        run_op(6'd44, 64'h7, 64'h8, 5'd5, 0, 64'h9999, 64'h0, 1'b1, 0);
        run_op(6'd63, 64'h7, 64'h8, 5'd31, 0, 64'h9999, 64'h0, 1'b1, 0);
        run_op(6'd38, 64'h11, 64'h22, 5'd6, 255, 64'h9999, 64'h0, 1'b1, 15);
        run_op(6'd39, 64'h33, 64'h44, 5'd8, 14, 64'h5555, 64'h5555, 1'b0, 15);

        // Backpressure: response held for 10 cycles while a new request is offered.
        rsp_ready = 1'b0;
        begin
            rsp_t e;
            e.data = 64'hABCD;
            e.rd = 5'd11;
            e.err = 1'b0;
            sb.push_back(e);
        end
        oval_at = 2;
        alu_out = 64'hABCD;
        exp_fn = 6'd40;
        exp_in1 = 64'h1;
        exp_in2 = 64'h2;
        drive_req(6'd40, 64'h1, 64'h2, 5'd11);
        @(posedge ise_clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            @(posedge ise_clk); #1;
        end
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        drive_req(6'd33, 64'hFFFF, 64'hEEEE, 5'd9);
        for (int i = 0; i < 10; i++) begin
            @(posedge ise_clk); #1;
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_hold_data", rsp_data, 64'hABCD);
            chk("bp_hold_rd", rsp_rd, 5'd11);
            chk("bp_no_capture", ise_fn, 6'd40);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge ise_clk); #1;
        chk("bp_release_idle", req_ready, 1'b1);
        chk("bp_release_rvalid", rsp_valid, 1'b0);
        chk("bp_done_cnt", done_cnt, exp_done);

        // Reset in the middle of BUSY aborts the operation.
        oval_at = 255;
        exp_fn = 6'd36;
        exp_in1 = 64'h77;
        exp_in2 = 64'h88;
        drive_req(6'd36, 64'h77, 64'h88, 5'd10);
        @(posedge ise_clk); #1;
        req_valid = 1'b0;
        chk("mid_busy_val", ise_val, 1'b1);
        #2;
        ise_rst = 1'b1;
        #1;
        chk("arst_ise_val", ise_val, 1'b0);
        chk("arst_ise_fn", ise_fn, 6'd0);
        chk("arst_ise_in1", ise_in1, 64'd0);
        chk("arst_ise_in2", ise_in2, 64'd0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_rsp_rd", rsp_rd, 5'd0);
        chk("arst_done_cnt", done_cnt, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_req_ready", req_ready, 1'b1);
        exp_done = 0;
        exp_err = 0;
        @(posedge ise_clk);
        @(posedge ise_clk); #1;
        ise_rst = 1'b0;
        chk("post_rst_ready", req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge ise_clk); #1;
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end

        run_op(6'd37, 64'h0123, 64'h4567, 5'd12, 1, 64'h89AB, 64'h89AB, 1'b0, 2);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ise_issue.md
ISE_ISSUE -- requirements
Module: ise_issue

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum BUSY cycles (1..255) to wait for ise_oval before an error response.
REQ-002 ise_clk  input  1  single clock; all state updates on rising edge.
REQ-003 ise_rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core offers an ISE operation.
REQ-005 req_ready  output  1  block accepts the operation this cycle.
REQ-006 req_fn  input  6  function code; legal range 32..43 inclusive.
REQ-007 req_rs1, req_rs2  input  64 each  source operands.
REQ-008 req_rd  input  5  destination register tag.
REQ-009 ise_fn  output  6  function code driven to the bit-manipulation ALU.
REQ-010 ise_in1, ise_in2  output  64 each  operands driven to the ALU.
REQ-011 ise_val  output  1  operation valid to the ALU.
REQ-012 ise_oval  input  1  ALU result valid, sampled in the same cycle as ise_val.
REQ-013 ise_out  input  64  ALU result.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  core consumes the response.
REQ-016 rsp_data  output  64  result; 0 on error.
REQ-017 rsp_rd  output  5  tag of the completed operation.
REQ-018 rsp_err  output  1  1 = illegal function or timeout.
REQ-019 done_cnt  output  32  responses delivered without error, wraps mod 2^32.
REQ-020 err_cnt  output  16  responses delivered with error, saturates at 16'hFFFF.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY, RESP; one operation outstanding at a time.
REQ-022 IDLE: req_ready=1, ise_val=0, rsp_valid=0.
REQ-023 IDLE with req_valid=1 and legal req_fn: capture fn, rs1, rs2, rd into holding registers, clear timeout counter, go BUSY.
REQ-024 IDLE with req_valid=1 and illegal req_fn: capture rd, set rsp_data=0, rsp_err=1, go RESP directly; ALU never driven.
REQ-025 BUSY: req_ready=0, ise_val=1, ise_fn/ise_in1/ise_in2 driven from holding registers and stable throughout BUSY.
REQ-026 ise_fn/ise_in1/ise_in2 SHALL be driven from holding registers in all states (no combinational path from req_* to ise_*).
REQ-027 BUSY with ise_oval=1: register ise_out into rsp_data, rsp_err=0, go RESP.
REQ-028 BUSY with ise_oval=0: increment timeout counter (8-bit); when counter reaches TIMEOUT-1 in that cycle, set rsp_data=0, rsp_err=1, go RESP (error after exactly TIMEOUT BUSY cycles).
REQ-029 ise_oval=1 in the same cycle as timeout expiry SHALL take precedence: success response.
REQ-030 ise_oval outside BUSY SHALL be ignored.
REQ-031 RESP: rsp_valid=1, req_ready=0, ise_val=0; rsp_data/rsp_rd/rsp_err held stable until handshake.
REQ-032 RESP with rsp_ready=1: go IDLE; increment done_cnt if rsp_err=0, else err_cnt (saturating).
REQ-033 Minimum latency: accept at cycle N, BUSY at N+1, rsp_valid at N+2; throughput one operation per 3 cycles.
REQ-034 rsp_ready while not in RESP and req_valid while not in IDLE SHALL have no effect.

Reset
REQ-035 ise_rst asserted SHALL immediately force IDLE and clear: holding registers, timeout counter, rsp_data, rsp_rd, rsp_err, done_cnt, err_cnt, ise_* outputs to 0.
REQ-036 Reset mid-BUSY or mid-RESP SHALL abort the operation with no response and no counter update.
REQ-037 After reset release, req_ready=1 in the first cycle.

Verification
REQ-038 Legal op: fn=35, rs1=64'hFF00, rs2=64'h0F00, rd=7, ALU returns oval=1, out=64'hF000 -> rsp_valid at cycle N+2, data=64'hF000, rd=7, err=0, done_cnt=1.
REQ-039 Illegal fn=12, rd=3 -> RESP at N+1, data=0, rd=3, err=1, ise_val never asserted, err_cnt=1.
REQ-040 ALU holds oval=0, TIMEOUT=15 -> ise_val high exactly 15 cycles, then rsp_err=1, data=0.
REQ-041 Backpressure: rsp_ready=0 for 10 cycles in RESP with req_valid=1 -> response stable, req_ready=0, no new capture; release -> IDLE next cycle.
REQ-042 Reset asserted during BUSY (cycle N+1) -> outputs 0 asynchronously, no rsp_valid, counters 0, req_ready=1 after release.
REQ-043 oval=1 on the final timeout cycle -> success response, err=0, done_cnt increments.
